// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// multdiv_unit : parametrised multiply/divide/accumulate unit with HI/LO
// Revision 1.0
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mdctr,
  input  logic             start,
  input  logic             hiwrite,
  input  logic             lowrite,
  input  logic             clr,
  output logic             busy,
  output logic [WIDTH-1:0] hio,
  output logic [WIDTH-1:0] loo
);

  localparam int c_MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int c_CW     = $clog2(c_MAXLAT + 1);
  localparam logic [c_CW-1:0] c_MULT_CNT = c_CW'(MULT_LAT - 1);
  localparam logic [c_CW-1:0] c_DIV_CNT  = c_CW'(DIV_LAT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [c_CW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_sh, r_sl;

  logic               w_signed_mul, w_div_class, w_div_zero, w_div_ovf;
  logic [2*WIDTH-1:0] w_ma, w_mb, w_prod, w_acc, w_result;
  logic [WIDTH-1:0]   w_sb_safe, w_ub_safe;
  logic [WIDTH-1:0]   w_squot, w_srem, w_uquot, w_urem;

  assign w_signed_mul = ~mdctr[0];
  assign w_div_class  = (mdctr[2:1] == 2'b01);

  // Extending to 2*WIDTH before multiplying gives a correct product either way.
  assign w_ma   = {{WIDTH{w_signed_mul & A[WIDTH-1]}}, A};
  assign w_mb   = {{WIDTH{w_signed_mul & B[WIDTH-1]}}, B};
  assign w_prod = w_ma * w_mb;
  assign w_acc  = {r_hi, r_lo};

  assign w_div_zero = (B == '0);
  assign w_div_ovf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  // Dummy divisor of 1 keeps the arithmetic trap-free; the result is overridden.
  assign w_sb_safe  = (w_div_zero | w_div_ovf) ? WIDTH'(1) : B;
  assign w_ub_safe  = w_div_zero ? WIDTH'(1) : B;

  assign w_squot = $signed(A) / $signed(w_sb_safe);
  assign w_srem  = $signed(A) % $signed(w_sb_safe);
  assign w_uquot = A / w_ub_safe;
  assign w_urem  = A % w_ub_safe;

  always_comb begin
    w_result = w_prod;
    case (mdctr)
      3'b000, 3'b001: w_result = w_prod;
      3'b010: begin
        if (w_div_zero)     w_result = {A, {WIDTH{1'b1}}};
        else if (w_div_ovf) w_result = {{WIDTH{1'b0}}, A};
        else                w_result = {w_srem, w_squot};
      end
      3'b011: begin
        if (w_div_zero) w_result = {A, {WIDTH{1'b1}}};
        else            w_result = {w_urem, w_uquot};
      end
      3'b100, 3'b101: w_result = w_acc + w_prod;
      default:        w_result = w_acc - w_prod;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sh    <= '0;
      r_sl    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!clr) begin
            if (start) begin
              r_state      <= S_RUN;
              {r_sh, r_sl} <= w_result;
              r_cnt        <= w_div_class ? c_DIV_CNT : c_MULT_CNT;
            end else begin
              if (hiwrite) r_hi <= A;
              if (lowrite) r_lo <= A;
            end
          end
        end
        S_RUN: begin
          // Flush wins over completion so HI/LO never see an aborted result.
          if (clr) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_hi    <= r_sh;
            r_lo    <= r_sl;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - c_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign hio  = r_hi;
  assign loo  = r_lo;

endmodule
`default_nettype wire
